// File: rtl/acc_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// acc_pkg
// Shared definitions for the accumulator sequencer: ALU op codes, the
// sequencer state type and small helpers used by acc_ctrl and its bench.
//   NUM_OPS      number of one-hot op requesters (one per op code)
//   OP_*         4-bit op codes driven to the external ALU
//   state_t      IDLE -> GRANT -> EXEC service sequence
//   is_carry_op  ops whose ALU carry-out is written into the carry flag
//   onehot_to_op converts a one-hot grant vector into its op code
// ----------------------------------------------------------------------------
package acc_pkg;

    localparam int NUM_OPS = 9;

    localparam logic [3:0] OP_SOMA = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_DE   = 4'd6;
    localparam logic [3:0] OP_DD   = 4'd7;
    localparam logic [3:0] OP_CARG = 4'd8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        EXEC  = 2'd2
    } state_t;

    // Arithmetic and shift ops produce a meaningful carry/borrow/shifted-out
    // bit; the logic ops and carg leave the carry flag untouched.
    function automatic logic is_carry_op(input logic [3:0] op);
        return (op == OP_SOMA) || (op == OP_SUB) || (op == OP_DE) || (op == OP_DD);
    endfunction

    // The grant is one-hot, so at most one bit contributes its index.
    function automatic logic [3:0] onehot_to_op(input logic [NUM_OPS-1:0] g);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (g[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/acc_ctrl_if.sv
// ----------------------------------------------------------------------------
// acc_ctrl_if
// Bundles the requester handshake and the external ALU connection of the
// accumulator sequencer.
//   req/ack          one-hot op requests and the one-cycle service pulse
//   operand          B operand supplied with the request
//   op/alu_a/alu_b   op code and operands presented to the ALU
//   alu_y/alu_cout   ALU result and carry/borrow/shift-out bit
//   acc/flag_z/flag_c/busy  accumulator state and sequencer status
// Modports: master = requesters + ALU side, slave = acc_ctrl.
// ----------------------------------------------------------------------------
interface acc_ctrl_if #(
    parameter int W = 8
);
    import acc_pkg::*;

    logic [NUM_OPS-1:0] req;
    logic [W-1:0]       operand;
    logic [W-1:0]       alu_y;
    logic               alu_cout;
    logic [3:0]         op;
    logic [W-1:0]       alu_a;
    logic [W-1:0]       alu_b;
    logic [NUM_OPS-1:0] ack;
    logic [W-1:0]       acc;
    logic               flag_z;
    logic               flag_c;
    logic               busy;

    modport master (
        output req, operand, alu_y, alu_cout,
        input  op, alu_a, alu_b, ack, acc, flag_z, flag_c, busy
    );

    modport slave (
        input  req, operand, alu_y, alu_cout,
        output op, alu_a, alu_b, ack, acc, flag_z, flag_c, busy
    );

endinterface

// File: rtl/acc_ctrl_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. Searches upward from i_ptr, wrapping
// from N-1 back to 0, and grants the first active request.
//   i_req  N-bit request vector
//   i_ptr  index with highest priority this round (0..N-1)
//   o_gnt  one-hot grant, all zero only when i_req is all zero
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 9
) (
    input  logic [N-1:0] i_req,
    input  logic [3:0]   i_ptr,
    output logic [N-1:0] o_gnt
);

    logic [4:0] w_pos;
    logic       w_found;

    // Walk the N candidate positions in priority order; the modulo-N wrap
    // keeps w_pos inside the request vector since i_ptr never exceeds N-1.
    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = {1'b0, i_ptr} + 5'(k);
            if (w_pos >= 5'(N)) begin
                w_pos = w_pos - 5'(N);
            end
            if (!w_found && i_req[w_pos[3:0]]) begin
                o_gnt[w_pos[3:0]] = 1'b1;
                w_found           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/acc_ctrl.sv
// ----------------------------------------------------------------------------
// acc_ctrl
// Sequencer/arbiter for the accumulator datapath. Picks one of up to nine
// op requesters round-robin, presents the op and operands to the external
// ALU, writes the result back into the accumulator with Z/C flags and acks
// the served requester. One op per three clocks: IDLE -> GRANT -> EXEC.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    acc_ctrl_if slave: req/operand/alu_y/alu_cout in,
//          op/alu_a/alu_b/ack/acc/flag_z/flag_c/busy out
// ----------------------------------------------------------------------------
module acc_ctrl
    import acc_pkg::*;
#(
    parameter int           W         = 8,
    parameter logic [W-1:0] RESET_ACC = '0
) (
    input  logic      clk,
    input  logic      rst_n,
    acc_ctrl_if.slave bus
);

    state_t             r_state;
    logic [NUM_OPS-1:0] r_grant;
    logic [NUM_OPS-1:0] r_ack;
    logic [3:0]         r_op;
    logic [3:0]         r_ptr;
    logic [W-1:0]       r_acc;
    logic [W-1:0]       r_aluB;
    logic               r_flagZ;
    logic               r_flagC;
    logic               r_busy;
    logic [NUM_OPS-1:0] w_gnt;

    rr_arbiter #(
        .N (NUM_OPS)
    ) u_arb (
        .i_req (bus.req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt)
    );

    // Service sequencer. The grant is captured in IDLE and then frozen, so
    // request changes during GRANT/EXEC cannot alter or cancel the op. The
    // ack is registered out of EXEC and is therefore visible in the next
    // IDLE cycle, which is also the cycle that arbitrates the next request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ack   <= '0;
            r_op    <= '0;
            r_ptr   <= '0;
            r_acc   <= RESET_ACC;
            r_aluB  <= '0;
            r_flagZ <= (RESET_ACC == '0);
            r_flagC <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_ack <= '0;
            case (r_state)
                IDLE: begin
                    if (|bus.req) begin
                        r_grant <= w_gnt;
                        r_busy  <= 1'b1;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    r_op    <= onehot_to_op(r_grant);
                    r_aluB  <= bus.operand;
                    r_state <= EXEC;
                end
                EXEC: begin
                    r_acc   <= bus.alu_y;
                    r_flagZ <= (bus.alu_y == '0);
                    if (is_carry_op(r_op)) begin
                        r_flagC <= bus.alu_cout;
                    end
                    r_ack   <= r_grant;
                    r_ptr   <= (r_op == OP_CARG) ? 4'd0 : r_op + 4'd1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.op     = r_op;
    assign bus.alu_a  = r_acc;
    assign bus.alu_b  = r_aluB;
    assign bus.ack    = r_ack;
    assign bus.acc    = r_acc;
    assign bus.flag_z = r_flagZ;
    assign bus.flag_c = r_flagC;
    assign bus.busy   = r_busy;

endmodule

// File: tb/tb_acc_ctrl.sv
// ----------------------------------------------------------------------------
// tb_acc_ctrl
// Self-checking bench for acc_ctrl (W=8). Plays the role of the requesters
// and of the external ALU, and predicts accumulator, flags, ack order and
// latency from a behavioural model of the sequencing rules.
// ----------------------------------------------------------------------------
module tb_acc_ctrl;
    import acc_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [8:0] rq;

    int assertCount;
    int failCount;

    int         mPtr;
    logic [7:0] mAcc;
    logic       mZ;
    logic       mC;

    acc_ctrl_if #(.W(8)) bus ();

    acc_ctrl #(
        .W         (8),
        .RESET_ACC (8'h00)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference ALU: returns {carry, result} for each op code.
    function automatic logic [8:0] aluModel(input logic [3:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
        case (op)
            OP_SOMA: return {1'b0, a} + {1'b0, b};
            OP_SUB:  return {1'b0, a} - {1'b0, b};
            OP_AND:  return {1'b0, a & b};
            OP_OR:   return {1'b0, a | b};
            OP_XOR:  return {1'b0, a ^ b};
            OP_NOT:  return {1'b0, ~a};
            OP_DE:   return {a[7], a[6:0], 1'b0};
            OP_DD:   return {a[0], 1'b0, a[7:1]};
            OP_CARG: return {1'b0, b};
            default: return 9'h000;
        endcase
    endfunction

    // External ALU driven combinationally from the sequencer outputs.
    assign {bus.alu_cout, bus.alu_y} = aluModel(bus.op, bus.alu_a, bus.alu_b);

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [8:0] reqMask, input logic [7:0] opnd);
        rq          = reqMask;
        bus.req     = reqMask;
        bus.operand = opnd;
    endtask

    task automatic modelReset();
        mPtr = 0;
        mAcc = 8'h00;
        mZ   = 1'b1;
        mC   = 1'b0;
    endtask

    // Serves one request starting from a negedge in an IDLE cycle with rq
    // already driven: predicts winner and writeback, waits (bounded) for the
    // ack and checks latency, ack, accumulator and flags.
    task automatic serviceOne(input logic [7:0] opnd, input bit dropAll, input bit dropInGrant);
        int         w;
        int         cycles;
        logic [8:0] yc;
        logic [8:0] expAck;
        w = -1;
        for (int k = 0; k < 9; k++) begin
            if (w < 0 && rq[(mPtr + k) % 9]) begin
                w = (mPtr + k) % 9;
            end
        end
        if (w < 0) begin
            $display("[TB] FAIL serviceSetup: observed empty request expected nonempty");
            $fatal(1, "[TB] serviceOne called without a request");
        end
        bus.operand = opnd;
        cycles = 0;
        while (cycles < 8) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) begin
                checkOutput("busyGrant", 32'(bus.busy), 32'd1);
                if (dropInGrant) begin
                    applyStimulus(9'h000, opnd);
                end
            end
            if (bus.ack != 9'h000) begin
                break;
            end
        end
        checkOutput("latency", 32'(cycles), 32'd3);
        yc   = aluModel(4'(w), mAcc, opnd);
        mAcc = yc[7:0];
        mZ   = (yc[7:0] == 8'h00);
        if (w inside {0, 1, 6, 7}) begin
            mC = yc[8];
        end
        mPtr = (w + 1) % 9;
        expAck    = '0;
        expAck[w] = 1'b1;
        checkOutput("ack", 32'(bus.ack), 32'(expAck));
        checkOutput("acc", 32'(bus.acc), 32'(mAcc));
        checkOutput("flagZ", 32'(bus.flag_z), 32'(mZ));
        checkOutput("flagC", 32'(bus.flag_c), 32'(mC));
        checkOutput("busyIdle", 32'(bus.busy), 32'd0);
        if (dropAll) begin
            applyStimulus(9'h000, opnd);
        end else begin
            applyStimulus(rq & ~expAck, opnd);
        end
    endtask

    initial begin
        int extra;
        clk         = 1'b0;
        rst_n       = 1'b0;
        assertCount = 0;
        failCount   = 0;
        applyStimulus(9'h000, 8'h00);
        modelReset();

        // Power-on reset values
        repeat (2) @(negedge clk);
        checkOutput("rstAcc", 32'(bus.acc), 32'h00);
        checkOutput("rstZ", 32'(bus.flag_z), 32'd1);
        checkOutput("rstC", 32'(bus.flag_c), 32'd0);
        checkOutput("rstAck", 32'(bus.ack), 32'd0);
        checkOutput("rstBusy", 32'(bus.busy), 32'd0);
        checkOutput("rstOp", 32'(bus.op), 32'd0);
        checkOutput("rstAluB", 32'(bus.alu_b), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idleNoAck", 32'(bus.ack), 32'd0);

        // carg 0x7F, then soma 0x81 wraps to zero with carry
        $display("[TB] load and add wrap");
        applyStimulus(9'h100, 8'h7F);
        serviceOne(8'h7F, 1'b1, 1'b0);
        checkOutput("cargValue", 32'(bus.acc), 32'h7F);
        applyStimulus(9'h001, 8'h81);
        serviceOne(8'h81, 1'b1, 1'b0);
        checkOutput("somaWrap", 32'(bus.acc), 32'h00);

        // d_e of 0x80 sets C and Z; a following and keeps C
        $display("[TB] shift carry and held carry");
        applyStimulus(9'h100, 8'h80);
        serviceOne(8'h80, 1'b1, 1'b0);
        applyStimulus(9'h040, 8'h00);
        serviceOne(8'h00, 1'b1, 1'b0);
        checkOutput("deCarry", 32'(bus.flag_c), 32'd1);
        applyStimulus(9'h004, 8'hF0);
        serviceOne(8'hF0, 1'b1, 1'b0);
        checkOutput("andHoldsC", 32'(bus.flag_c), 32'd1);

        // Pointer at 5 after op 4: bit 7 wins over bit 2, then bit 2
        $display("[TB] round robin wrap");
        applyStimulus(9'h010, 8'h3C);
        serviceOne(8'h3C, 1'b1, 1'b0);
        applyStimulus(9'h084, 8'h11);
        serviceOne(8'h11, 1'b0, 1'b0);
        serviceOne(8'h22, 1'b0, 1'b0);

        // Request dropped during GRANT still completes exactly once
        $display("[TB] drop during grant");
        applyStimulus(9'h002, 8'h05);
        serviceOne(8'h05, 1'b1, 1'b1);
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.ack != 9'h000) extra++;
        end
        checkOutput("noRepeat", 32'(extra), 32'd0);

        // Reset in the middle of EXEC aborts the op
        $display("[TB] reset during exec");
        applyStimulus(9'h100, 8'h3C);
        serviceOne(8'h3C, 1'b1, 1'b0);
        applyStimulus(9'h001, 8'h10);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("midRstAcc", 32'(bus.acc), 32'h00);
        checkOutput("midRstAck", 32'(bus.ack), 32'd0);
        checkOutput("midRstBusy", 32'(bus.busy), 32'd0);
        checkOutput("midRstZ", 32'(bus.flag_z), 32'd1);
        @(negedge clk);
        applyStimulus(9'h000, 8'h00);
        rst_n = 1'b1;
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.ack != 9'h000) extra++;
        end
        checkOutput("abortNoAck", 32'(extra), 32'd0);
        checkOutput("abortAcc", 32'(bus.acc), 32'h00);

        // All requests held: served 0..8 in order, one every three clocks
        $display("[TB] full request sweep");
        applyStimulus(9'h1FF, 8'h01);
        for (int i = 0; i < 9; i++) begin
            serviceOne(8'($urandom_range(0, 255)), 1'b0, 1'b0);
        end
        checkOutput("sweepEmpty", 32'(rq), 32'd0);

        // Random request mixes and operands against the model
        $display("[TB] random traffic");
        for (int i = 0; i < 40; i++) begin
            applyStimulus(rq | 9'($urandom_range(1, 511)), 8'($urandom_range(0, 255)));
            serviceOne(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
        end
        applyStimulus(9'h000, 8'h00);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
